mat_mult_engine: RTL and testbench

MAT_MULT_ENGINE -- requirements
Module: mat_mult_engine

---
 rtl/mat_mult_engine.sv | 150 +++++++++++++++
 tb/tb_mat_mult_engine.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/mat_mult_engine.sv
// NxN matrix multiply, LANES result elements issued per cycle through a two-stage (product, sum) pipeline.
// done is high in the cycle after edge t+K+1; start is ignored while busy, so nothing is ever queued.
module mat_mult_engine #(
    parameter int N     = 4,
    parameter int W     = 4,
    parameter int LANES = 2,
    localparam int OW   = 2*W + $clog2(N)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                sgn,
    input  logic                acc,
    input  logic [N*N*W-1:0]    mat_A,
    input  logic [N*N*W-1:0]    mat_B,
    output logic [N*N*OW-1:0]   mat_out,
    output logic                busy,
    output logic                done
);

    localparam int NE = N*N;
    localparam int K  = NE / LANES;
    localparam int KW = (K > 1) ? $clog2(K) : 1;

    if ((NE % LANES) != 0) begin : g_bad_lanes
        $error("mat_mult_engine: N*N must be divisible by LANES");
    end
    if (N < 2) begin : g_bad_n
        $error("mat_mult_engine: N must be at least 2");
    end

    typedef enum logic [1:0] {IDLE, CALC, DRAIN, DONE} state_t;

    state_t             state_q, state_d;
    logic [KW-1:0]      k_q, k_d;
    logic [KW-1:0]      grp_q, grp_d;
    logic               pv_q, pv_d;
    logic [NE*W-1:0]    a_q, a_d;
    logic [NE*W-1:0]    b_q, b_d;
    logic               sgn_q, sgn_d;
    logic               acc_q, acc_d;
    logic [OW-1:0]      prod_q [LANES][N];
    logic [OW-1:0]      prod_d [LANES][N];
    logic [NE*OW-1:0]   out_q, out_d;
    logic [OW-1:0]      sum;

    function automatic logic [OW-1:0] ext(input logic [W-1:0] v);
        return sgn_q ? {{(OW-W){v[W-1]}}, v} : {{(OW-W){1'b0}}, v};
    endfunction

    // Product of A[row(e)][m] and B[m][col(e)]; OW-bit wrap keeps signed products exact.
    function automatic logic [OW-1:0] prod_fn(input int e, input int m);
        logic [W-1:0] av;
        logic [W-1:0] bv;
        av = a_q[(NE-1-((e/N)*N+m))*W +: W];
        bv = b_q[(NE-1-(m*N+(e%N)))*W +: W];
        return ext(av) * ext(bv);
    endfunction

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        grp_d   = grp_q;
        pv_d    = 1'b0;
        a_d     = a_q;
        b_d     = b_q;
        sgn_d   = sgn_q;
        acc_d   = acc_q;
        prod_d  = prod_q;
        out_d   = out_q;
        sum     = '0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = mat_A;
                    b_d     = mat_B;
                    sgn_d   = sgn;
                    acc_d   = acc;
                    k_d     = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                for (int j = 0; j < LANES; j++) begin
                    for (int m = 0; m < N; m++) begin
                        prod_d[j][m] = prod_fn(int'(k_q)*LANES + j, m);
                    end
                end
                pv_d  = 1'b1;
                grp_d = k_q;
                if (int'(k_q) == K-1) begin
                    state_d = DRAIN;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            DRAIN:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Stage 2 retires whatever group stage 1 registered on the previous edge.
        if (pv_q) begin
            for (int j = 0; j < LANES; j++) begin
                sum = '0;
                for (int m = 0; m < N; m++) begin
                    sum = sum + prod_q[j][m];
                end
                out_d[(NE-1-(int'(grp_q)*LANES+j))*OW +: OW] =
                    acc_q ? out_q[(NE-1-(int'(grp_q)*LANES+j))*OW +: OW] + sum : sum;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            k_q     <= '0;
            grp_q   <= '0;
            pv_q    <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sgn_q   <= 1'b0;
            acc_q   <= 1'b0;
            out_q   <= '0;
            for (int j = 0; j < LANES; j++) begin
                for (int m = 0; m < N; m++) begin
                    prod_q[j][m] <= '0;
                end
            end
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            grp_q   <= grp_d;
            pv_q    <= pv_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sgn_q   <= sgn_d;
            acc_q   <= acc_d;
            out_q   <= out_d;
            prod_q  <= prod_d;
        end
    end

    assign mat_out = out_q;
    assign busy    = (state_q != IDLE);
    assign done    = (state_q == DONE);

endmodule

// File: tb/tb_mat_mult_engine.sv
// Randomised and directed bench for mat_mult_engine (N=4, W=4, LANES=2) against a plain-arithmetic matrix model.
module tb_mat_mult_engine;

    localparam int N  = 4;
    localparam int W  = 4;
    localparam int OW = 10;
    localparam int NE = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              sgn;
    logic              acc;
    logic [NE*W-1:0]   mat_A;
    logic [NE*W-1:0]   mat_B;
    logic [NE*OW-1:0]  mat_out;
    logic              busy;
    logic              done;

    logic [W-1:0]  a_arr [NE];
    logic [W-1:0]  b_arr [NE];
    logic [OW-1:0] ref_c [NE];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mat_mult_engine #(.N(N), .W(W), .LANES(2)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .sgn     (sgn),
        .acc     (acc),
        .mat_A   (mat_A),
        .mat_B   (mat_B),
        .mat_out (mat_out),
        .busy    (busy),
        .done    (done)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [OW-1:0] get_c(input int i);
        return mat_out[(NE-1-i)*OW +: OW];
    endfunction

    function automatic int to_int(input logic [W-1:0] v, input logic s);
        int x;
        x = int'(v);
        if (s && x >= (1 << (W-1))) x = x - (1 << W);
        return x;
    endfunction

    // C = A x B (+ previous C when accumulating), reduced mod 2^OW.
    task automatic model(input logic s, input logic a);
        for (int i = 0; i < NE; i++) begin
            int r, c, total;
            r = i / N;
            c = i % N;
            total = 0;
            for (int m = 0; m < N; m++) begin
                total += to_int(a_arr[r*N+m], s) * to_int(b_arr[m*N+c], s);
            end
            if (a) total += int'(ref_c[i]);
            ref_c[i] = OW'(total & ((1 << OW) - 1));
        end
    endtask

    task automatic pack();
        for (int i = 0; i < NE; i++) begin
            mat_A[(NE-1-i)*W +: W] = a_arr[i];
            mat_B[(NE-1-i)*W +: W] = b_arr[i];
        end
    endtask

    task automatic scramble();
        mat_A = {$urandom, $urandom};
        mat_B = {$urandom, $urandom};
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < NE; i++) chk(tag, 64'(get_c(i)), 64'(ref_c[i]));
    endtask

    // mode 0: plain; 1: inputs change every cycle; 2: extra start pulse in the 3rd CALC cycle
    task automatic do_op(input logic s, input logic a, input int mode);
        int first_done;
        int n_done;
        int n_busy;
        first_done = -1;
        n_done = 0;
        n_busy = 0;
        model(s, a);
        pack();
        sgn = s;
        acc = a;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 0; c < 14; c++) begin
            if (c > 0) begin
                @(posedge clk); #1;
            end
            start = 1'b0;
            if (busy) n_busy++;
            if (done) begin
                n_done++;
                if (first_done < 0) begin
                    first_done = c;
                    check_all("result");
                end
            end
            if (mode == 1) begin
                scramble();
                sgn = ~sgn;
                acc = ~acc;
            end
            if (mode == 2 && c == 2) begin
                scramble();
                start = 1'b1;
            end
        end
        chk("latency", 64'(first_done), 64'd9);
        chk("busy_cycles", 64'(n_busy), 64'd10);
        chk("done_pulses", 64'(n_done), 64'd1);
        check_all("idle_hold");
    endtask

    task automatic fill(input int av, input int bv);
        for (int i = 0; i < NE; i++) begin
            a_arr[i] = W'(av);
            b_arr[i] = W'(bv);
        end
    endtask

    task automatic fill_rand();
        for (int i = 0; i < NE; i++) begin
            a_arr[i] = W'($urandom);
            b_arr[i] = W'($urandom);
        end
    endtask

    initial begin
        int n_done;
        rst = 1'b1;
        start = 1'b0;
        sgn = 1'b0;
        acc = 1'b0;
        mat_A = '0;
        mat_B = '0;
        for (int i = 0; i < NE; i++) ref_c[i] = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_out", 64'(|mat_out), 64'd0);
        rst = 1'b0;

        // identity x (0..15)
        for (int i = 0; i < NE; i++) begin
            a_arr[i] = ((i / N) == (i % N)) ? W'(1) : W'(0);
            b_arr[i] = W'(i);
        end
        do_op(1'b0, 1'b0, 0);
        chk("ident_c7", 64'(get_c(7)), 64'd7);
        chk("ident_c15", 64'(get_c(15)), 64'd15);

        fill(15, 15);
        do_op(1'b0, 1'b0, 0);
        chk("all15", 64'(get_c(5)), 64'd900);
        do_op(1'b0, 1'b1, 0);
        chk("all15_acc", 64'(get_c(10)), 64'd776);

        fill(8, 8);
        do_op(1'b1, 1'b0, 0);
        chk("neg8sq", 64'(get_c(0)), 64'd256);
        fill(15, 1);
        do_op(1'b1, 1'b0, 0);
        chk("neg1", 64'(get_c(3)), 64'h3FC);

        fill_rand();
        do_op(1'b0, 1'b0, 2);
        fill_rand();
        do_op(1'b1, 1'b1, 1);

        for (int t = 0; t < 6; t++) begin
            fill_rand();
            do_op(1'($urandom), 1'($urandom), 0);
        end

        // reset in the 5th CALC cycle
        fill_rand();
        pack();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_done", 64'(done), 64'd0);
        chk("midrst_out", 64'(|mat_out), 64'd0);
        for (int i = 0; i < NE; i++) ref_c[i] = '0;
        n_done = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            if (done) n_done++;
        end
        chk("midrst_nodone", 64'(n_done), 64'd0);

        // first accumulate after reset builds on zero
        fill_rand();
        do_op(1'b0, 1'b1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
